dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store port: it accepts one word-aligned read or write at a time over a valid/ready request channel and returns completion over a valid/ready response channel.
- Models a data RAM with a programmable number of wait states, so the core and its later pipelined variants can be verified against a non-zero-latency memory.
- Sits between the core's data-memory interface and the RAM storage array. Flags misaligned and out-of-range accesses instead of performing them.

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the core's load/store port. Accepts one
// word-aligned load or store at a time on a valid/ready request channel,
// waits a programmable number of cycles, performs the access, then holds the
// completion on a valid/ready response channel until the initiator takes it.
// Misaligned or out-of-range requests are flagged with rsp_err and never
// touch the storage array.
//
// Parameters:
//   ADDR_WIDTH  - log2 of memory depth in 32-bit words (2..29)
//   WAIT_STATES - idle cycles between accept and access (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  initiator has a request
//   req_ready  responder can accept a request this cycle (IDLE, not in reset)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables, bit i selects lane [8i+7:8i]
//   rsp_valid  response available
//   rsp_ready  initiator accepts the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    request was misaligned or out of range
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  wait_cnt;

  // Request fields captured at the accept edge; the live req_* inputs are
  // ignored for the rest of the transaction.
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH];

  logic                  access;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] word_idx;

  // The access happens on the WAIT edge that finds the counter at zero, so
  // rsp_valid rises WAIT_STATES+1 edges after the accept edge.
  assign access   = (state == ST_WAIT) && (wait_cnt == 4'd0);
  assign addr_err = (lat_addr[1:0] != 2'b00) ||
                    (lat_addr[31:ADDR_WIDTH+2] != '0);
  assign word_idx = lat_addr[ADDR_WIDTH+1:2];

  // Gated with rst so a request is never advertised while reset is held.
  assign req_ready = (state == ST_IDLE) && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            wait_cnt  <= 4'(WAIT_STATES);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= addr_err;
            rsp_rdata <= (!lat_we && !addr_err) ? mem[word_idx] : 32'd0;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; it maps onto plain RAM, and its
  // contents are expected to survive a controller reset.
  always_ff @(posedge clk) begin
    if (access && lat_we && !addr_err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // DUT with two wait states.
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  // DUT with zero wait states, response channel always ready.
  logic        req_valid0 = 1'b0, req_ready0, req_we0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic [3:0]  req_be0 = '0;
  logic        rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(1'b1),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request to the WAIT_STATES=2 DUT, check latency and response,
  // then complete the handshake. Starts and ends on a falling edge.
  task automatic run_txn(input vec_t v);
    int edges;
    bit seen;
    @(negedge clk);
    check({v.name, ".req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    // Scramble the request inputs: the in-flight transaction must not see them.
    req_we    = ~v.we;
    req_addr  = 32'h0000_0044;
    req_wdata = 32'h5555_5555;
    req_be    = 4'hF;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: rsp_valid never rose", v.name);
    end else begin
      check({v.name, ".latency"}, edges, 3);
      check({v.name, ".rdata"}, rsp_rdata, v.exp_rdata);
      check({v.name, ".err"}, rsp_err, v.exp_err);
      check({v.name, ".req_ready_resp"}, req_ready, 0);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({v.name, ".rsp_valid_clr"}, rsp_valid, 0);
      check({v.name, ".req_ready_back"}, req_ready, 1);
    end
  endtask

  // Drive a request and wait until the response is presented (no handshake).
  task automatic start_and_wait(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, output bit seen);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_and_wait.timeout: rsp_valid never rose");
    end
  endtask

  initial begin
    bit seen;

    vecs.push_back('{"st_10",      1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 0});
    vecs.push_back('{"ld_10",      0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0});
    vecs.push_back('{"st_20",      1, 32'h20,  32'h11223344, 4'hF, 32'h0, 0});
    vecs.push_back('{"st_20_part", 1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0, 0});
    vecs.push_back('{"ld_20",      0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 0});
    vecs.push_back('{"ld_mis",     0, 32'h22,  32'h0,        4'h0, 32'h0, 1});
    vecs.push_back('{"st_00",      1, 32'h0,   32'h12345678, 4'hF, 32'h0, 0});
    vecs.push_back('{"st_oor",     1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1});
    vecs.push_back('{"ld_00",      0, 32'h0,   32'h0,        4'h0, 32'h12345678, 0});
    vecs.push_back('{"st_be0",     1, 32'h10,  32'h00000000, 4'h0, 32'h0, 0});
    vecs.push_back('{"ld_10_be0",  0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0});
    vecs.push_back('{"st_top",     1, 32'h3FC, 32'h5A5A5A5A, 4'hF, 32'h0, 0});
    vecs.push_back('{"ld_top",     0, 32'h3FC, 32'h0,        4'h0, 32'h5A5A5A5A, 0});
    vecs.push_back('{"ld_hi_oor",  0, 32'h80000010, 32'h0,   4'h0, 32'h0, 1});
    vecs.push_back('{"st_30",      1, 32'h30,  32'h0BADC0DE, 4'hF, 32'h0, 0});

    // Reset state.
    #1;
    check("rst.req_ready", req_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_rdata", rsp_rdata, 0);
    check("rst.rsp_err",   rsp_err,   0);
    check("rst.req_ready0", req_ready0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Backpressure: response held stable for 5 cycles.
    start_and_wait(1'b0, 32'h10, 32'h0, seen);
    if (seen) begin
      for (int c = 0; c < 5; c++) begin
        check($sformatf("bp%0d.rsp_valid", c), rsp_valid, 1);
        check($sformatf("bp%0d.rsp_rdata", c), rsp_rdata, 32'hDEADBEEF);
        check($sformatf("bp%0d.rsp_err", c),   rsp_err,   0);
        check($sformatf("bp%0d.req_ready", c), req_ready, 0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp.rsp_valid_clr", rsp_valid, 0);
      check("bp.rsp_rdata_clr", rsp_rdata, 0);
      check("bp.req_ready_back", req_ready, 1);
    end

    // Reset during WAIT of a store: store is discarded.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort.rsp_valid", rsp_valid, 0);
    check("abort.req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn('{"ld_30_after_abort", 0, 32'h30, 32'h0, 4'h0, 32'h0BADC0DE, 0});

    // Reset while a response is presented: it is dropped.
    start_and_wait(1'b0, 32'h10, 32'h0, seen);
    if (seen) begin
      rst = 1'b1;
      #1;
      check("rspdrop.rsp_valid", rsp_valid, 0);
      check("rspdrop.rsp_rdata", rsp_rdata, 0);
      check("rspdrop.rsp_err",   rsp_err,   0);
      @(negedge clk);
      rst = 1'b0;
    end
    run_txn('{"ld_10_after_drop", 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0});

    // Zero wait states, rsp_ready tied high: one transaction every 3 cycles.
    @(negedge clk);
    check("ws0.req_ready_idle", req_ready0, 1);
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h40;
    req_wdata0 = 32'h01234567; req_be0 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_we0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      check($sformatf("ws0.k%0d.rsp_valid", k), rsp_valid0, (k % 3 == 1));
      check($sformatf("ws0.k%0d.req_ready", k), req_ready0, (k % 3 == 2));
      if (k % 3 == 1) begin
        check($sformatf("ws0.k%0d.rdata", k), rsp_rdata0,
              (k == 1) ? 32'h0 : 32'h01234567);
        check($sformatf("ws0.k%0d.err", k), rsp_err0, 0);
      end
    end
    req_valid0 = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
